ip_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that owns the IP segment register's control inputs (EN, SEL, D).
- Issues byte reads to program memory at the current IP and buffers the returned bytes in a small prefetch queue for the decoder.
- Handles jumps by reloading IP, flushing the queue and cancelling any in-flight fetch.
- Sits between the IP register, the memory interface and the decode stage.

---
 rtl/ip_fetch_ctrl_if.sv | 19 +
 rtl/ip_fetch_ctrl.sv | 157 +++++++++++++++
 tb/tb_ip_fetch_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ip_fetch_ctrl_if.sv
// rtl/ip_fetch_ctrl_if.sv - program-memory read bus between fetch sequencer and memory
// Purpose: groups the single-outstanding byte-read handshake.
//   mem_req   : read request, held with a stable mem_addr until mem_ack
//   mem_addr  : byte address
//   mem_ack   : read complete, mem_rdata valid this cycle
//   mem_rdata : returned byte
// master modport = requester (fetch sequencer), slave modport = memory.
interface ip_fetch_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/ip_fetch_ctrl.sv
// rtl/ip_fetch_ctrl.sv - instruction-fetch sequencer with prefetch queue and jump flush
// Purpose: drives the IP register controls, issues byte reads at the current IP,
// buffers returned bytes for the decoder and handles jump reload/flush.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_fetch_en            : allow new fetch launches
//   i_ip_q                : current IP register value
//   o_ip_en/o_ip_sel/o_ip_d : IP register enable, 0=increment 1=load, load value
//   mem                   : program-memory read bus (master side)
//   i_jmp_valid/i_jmp_target : single-cycle jump pulse and target
//   o_q_valid/o_q_data/i_q_ready/o_q_count : prefetch queue head and occupancy
module ip_fetch_ctrl #(
  parameter  int AW     = 8,
  parameter  int DW     = 8,
  parameter  int QDEPTH = 4,
  localparam int CW     = $clog2(QDEPTH + 1),
  localparam int PW     = $clog2(QDEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fetch_en,
  input  logic [AW-1:0]         i_ip_q,
  output logic                  o_ip_en,
  output logic                  o_ip_sel,
  output logic [AW-1:0]         o_ip_d,
  ip_fetch_ctrl_if.master       mem,
  input  logic                  i_jmp_valid,
  input  logic [AW-1:0]         i_jmp_target,
  output logic                  o_q_valid,
  output logic [DW-1:0]         o_q_data,
  input  logic                  i_q_ready,
  output logic [CW-1:0]         o_q_count
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_mem_req, w_mem_req_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_q_mem [QDEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_push, w_flush, w_ip_en, w_ip_sel;
  logic [CW:0]   w_cnt_after;
  logic          w_room_now, w_room_next;

  assign w_pop       = o_q_valid && i_q_ready;
  assign w_room_now  = r_count < CW'(QDEPTH);
  // Occupancy after this cycle's push and pop; the follow-on fetch needs a free
  // slot reserved beyond that.
  assign w_cnt_after = {1'b0, r_count} + (CW+1)'(1) - (CW+1)'(w_pop);
  assign w_room_next = w_cnt_after < (CW+1)'(QDEPTH);

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    w_ip_en        = 1'b0;
    w_ip_sel       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_jmp_valid) begin
          w_ip_en  = 1'b1;
          w_ip_sel = 1'b1;
          w_flush  = 1'b1;
        end else if (i_fetch_en && w_room_now) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = i_ip_q;
          w_state_nxt    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_jmp_valid) begin
          w_ip_en  = 1'b1;
          w_ip_sel = 1'b1;
          w_flush  = 1'b1;
          if (mem.mem_ack) begin
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end else begin
            w_state_nxt   = S_DISCARD;
          end
        end else if (mem.mem_ack) begin
          w_push  = 1'b1;
          w_ip_en = 1'b1;
          if (i_fetch_en && w_room_next) begin
            // IP increments this cycle, so the next byte lives at ip_q+1.
            w_mem_addr_nxt = i_ip_q + AW'(1);
          end else begin
            w_mem_req_nxt = 1'b0;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      S_DISCARD: begin
        if (i_jmp_valid) begin
          w_ip_en  = 1'b1;
          w_ip_sel = 1'b1;
          w_flush  = 1'b1;
        end
        if (mem.mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < QDEPTH; i++) r_q_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q_mem[r_wptr] <= mem.mem_rdata;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // IP controls are held inactive while reset is asserted.
  assign o_ip_en      = i_rst_n && w_ip_en;
  assign o_ip_sel     = i_rst_n && w_ip_sel;
  assign o_ip_d       = i_rst_n ? i_jmp_target : '0;
  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;
  assign o_q_valid    = r_count != '0;
  assign o_q_data     = r_q_mem[r_rptr];
  assign o_q_count    = r_count;

endmodule

// File: tb/tb_ip_fetch_ctrl.sv
// tb/tb_ip_fetch_ctrl.sv - directed self-checking bench for ip_fetch_ctrl
module tb_ip_fetch_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_en;
  logic [7:0] ip_q;
  logic       ip_en, ip_sel;
  logic [7:0] ip_d;
  logic       jmp_valid;
  logic [7:0] jmp_target;
  logic       q_valid, q_ready;
  logic [7:0] q_data;
  logic [2:0] q_count;

  int total = 0;
  int bad   = 0;

  logic       auto_mem;
  int         age;
  int         inc_cnt;
  logic [7:0] ack_log[$];
  logic       ack_d, req_d, en_d, sel_d;
  logic [7:0] d_d;

  ip_fetch_ctrl_if #(.AW(8), .DW(8)) bus ();

  ip_fetch_ctrl #(.AW(8), .DW(8), .QDEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fetch_en   (fetch_en),
    .i_ip_q       (ip_q),
    .o_ip_en      (ip_en),
    .o_ip_sel     (ip_sel),
    .o_ip_d       (ip_d),
    .mem          (bus.master),
    .i_jmp_valid  (jmp_valid),
    .i_jmp_target (jmp_target),
    .o_q_valid    (q_valid),
    .o_q_data     (q_data),
    .i_q_ready    (q_ready),
    .o_q_count    (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: memory model and IP register model ride along with the DUT.
  task automatic cyc();
    @(negedge clk);
    if (auto_mem) begin
      bus.mem_ack   = bus.mem_req && (age >= 1);
      bus.mem_rdata = bus.mem_addr ^ 8'hFF;
    end
    #1;
    if (bus.mem_ack && bus.mem_req) ack_log.push_back(bus.mem_addr);
    if (ip_en && !ip_sel) inc_cnt++;
    ack_d = bus.mem_ack;
    req_d = bus.mem_req;
    en_d  = ip_en;
    sel_d = ip_sel;
    d_d   = ip_d;
    @(posedge clk);
    #1;
    age = ack_d ? 0 : (req_d ? age + 1 : 0);
    if (en_d) ip_q = sel_d ? d_d : ip_q + 8'd1;
  endtask

  logic [7:0] exp_fill[4];
  logic [7:0] exp_wrap[4];

  initial begin
    exp_fill = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_wrap = '{8'hFF, 8'h00, 8'h01, 8'h02};
    rst_n = 1'b0; fetch_en = 1'b0; ip_q = 8'h10; jmp_valid = 1'b0; jmp_target = 8'h55;
    q_ready = 1'b0; auto_mem = 1'b1; age = 0; inc_cnt = 0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    cyc(); cyc();
    check("rst_req",   32'(bus.mem_req),  0);
    check("rst_addr",  32'(bus.mem_addr), 0);
    check("rst_qv",    32'(q_valid),      0);
    check("rst_qcnt",  32'(q_count),      0);
    check("rst_qdata", 32'(q_data),       0);
    check("rst_ipen",  32'(ip_en),        0);
    check("rst_ipsel", 32'(ip_sel),       0);
    check("rst_ipd",   32'(ip_d),         0);

    // Fill from 0x10 with back-to-back fetches.
    rst_n = 1'b1; fetch_en = 1'b1; jmp_target = 8'h00;
    ack_log.delete(); inc_cnt = 0;
    cyc();
    check("launch_req",  32'(bus.mem_req),  1);
    check("launch_addr", 32'(bus.mem_addr), 32'h10);
    for (int n = 0; n < 40 && !(q_count == 3'd4 && !bus.mem_req); n++) cyc();
    check("fill_cnt", 32'(q_count),     4);
    check("fill_req", 32'(bus.mem_req), 0);
    check("fill_inc", 32'(inc_cnt),     4);
    check("fill_n",   32'(ack_log.size()), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fill_addr%0d", i), (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hDEAD, 32'(exp_fill[i]));
    cyc(); cyc();
    check("full_hold_req", 32'(bus.mem_req), 0);
    check("full_head",     32'(q_data),      32'hEF);

    // Single pop, then relaunch at 0x14 which the memory holds unanswered.
    q_ready = 1'b1;
    cyc();
    q_ready = 1'b0; auto_mem = 1'b0; bus.mem_ack = 1'b0;
    check("pop_cnt",  32'(q_count), 3);
    check("pop_head", 32'(q_data),  32'hEE);
    cyc();
    check("relaunch_req",  32'(bus.mem_req),  1);
    check("relaunch_addr", 32'(bus.mem_addr), 32'h14);

    // Jump while the 0x14 request is outstanding.
    jmp_valid = 1'b1; jmp_target = 8'h80;
    #1;
    check("jmp_ipen",  32'(ip_en),  1);
    check("jmp_ipsel", 32'(ip_sel), 1);
    check("jmp_ipd",   32'(ip_d),   32'h80);
    cyc();
    jmp_valid = 1'b0;
    check("jmp_qcnt", 32'(q_count),      0);
    check("jmp_qv",   32'(q_valid),      0);
    check("jmp_req",  32'(bus.mem_req),  1);
    check("jmp_addr", 32'(bus.mem_addr), 32'h14);
    cyc(); cyc();
    check("disc_addr", 32'(bus.mem_addr), 32'h14);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h33;
    #1;
    check("disc_ack_ipen", 32'(ip_en), 0);
    cyc();
    bus.mem_ack = 1'b0;
    check("disc_done_req",  32'(bus.mem_req), 0);
    check("disc_done_qcnt", 32'(q_count),     0);
    check("disc_ip",        32'(ip_q),        32'h80);
    cyc();
    check("tgt_req",  32'(bus.mem_req),  1);
    check("tgt_addr", 32'(bus.mem_addr), 32'h80);

    // Jump in the same cycle as the ack.
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h44; jmp_valid = 1'b1; jmp_target = 8'h20;
    #1;
    check("jack_ipen",  32'(ip_en),  1);
    check("jack_ipsel", 32'(ip_sel), 1);
    check("jack_ipd",   32'(ip_d),   32'h20);
    cyc();
    bus.mem_ack = 1'b0; jmp_valid = 1'b0;
    check("jack_req",  32'(bus.mem_req), 0);
    check("jack_qcnt", 32'(q_count),     0);
    check("jack_ip",   32'(ip_q),        32'h20);
    cyc();
    check("jack_refetch_req",  32'(bus.mem_req),  1);
    check("jack_refetch_addr", 32'(bus.mem_addr), 32'h20);

    // fetch_en low: outstanding fetch completes, nothing new launches.
    fetch_en = 1'b0; auto_mem = 1'b1; age = 0;
    for (int n = 0; n < 10 && bus.mem_req; n++) cyc();
    cyc();
    check("fen0_req",  32'(bus.mem_req), 0);
    check("fen0_qcnt", 32'(q_count),     1);
    check("fen0_head", 32'(q_data),      32'hDF);

    // Address wrap from 0xFF.
    q_ready = 1'b1;
    cyc();
    q_ready = 1'b0;
    check("drain_qcnt", 32'(q_count), 0);
    ip_q = 8'hFF; ack_log.delete(); fetch_en = 1'b1;
    for (int n = 0; n < 40 && !(q_count == 3'd4 && !bus.mem_req); n++) cyc();
    check("wrap_n", 32'(ack_log.size()), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_addr%0d", i), (i < ack_log.size()) ? 32'(ack_log[i]) : 32'hDEAD, 32'(exp_wrap[i]));
    check("wrap_head", 32'(q_data), 32'h00);

    // Asynchronous reset with a request outstanding and two bytes queued.
    fetch_en = 1'b0; q_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    q_ready = 1'b0;
    check("pre_rst_empty", 32'(q_count), 0);
    fetch_en = 1'b1;
    for (int n = 0; n < 20 && q_count != 3'd2; n++) cyc();
    auto_mem = 1'b0; bus.mem_ack = 1'b0;
    check("pre_rst_qcnt", 32'(q_count),     2);
    check("pre_rst_req",  32'(bus.mem_req), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_req",  32'(bus.mem_req), 0);
    check("arst_qv",   32'(q_valid),     0);
    check("arst_qcnt", 32'(q_count),     0);
    bus.mem_ack = 1'b1; fetch_en = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    check("late_ack_ipen", 32'(ip_en), 0);
    cyc(); cyc();
    check("late_ack_qcnt", 32'(q_count),     0);
    check("late_ack_req",  32'(bus.mem_req), 0);
    check("late_ack_qv",   32'(q_valid),     0);
    bus.mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
